instr_sequencer: RTL

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/instr_sequencer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - instruction sequencer FSM
// Moore control FSM for a simple datapath with a latched instruction and a retired-instruction counter.
module instr_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       s,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic       w,
  output logic [2:0] nsel,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       asel,
  output logic       bsel,
  output logic       write,
  output logic [1:0] vsel,
  output logic [1:0] ALUop,
  output logic       err,
  output logic [7:0] retired
);

  typedef enum logic [2:0] {
    ST_WAIT      = 3'd0,
    ST_DECODE    = 3'd1,
    ST_GETA      = 3'd2,
    ST_GETB      = 3'd3,
    ST_ALU       = 3'd4,
    ST_WRITE_REG = 3'd5,
    ST_WRITE_IMM = 3'd6,
    ST_ERROR     = 3'd7
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] opcode_q, opcode_d;
  logic [1:0] op_q, op_d;
  logic [7:0] retired_q, retired_d;

  logic is_movreg, is_mvn, is_cmp;

  assign is_movreg = (opcode_q == 3'b110) && (op_q == 2'b00);
  assign is_mvn    = (opcode_q == 3'b101) && (op_q == 2'b11);
  assign is_cmp    = (opcode_q == 3'b101) && (op_q == 2'b01);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_WAIT;
      opcode_q  <= 3'b000;
      op_q      <= 2'b00;
      retired_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      op_q      <= op_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    op_d      = op_q;
    retired_d = retired_q;
    case (state_q)
      ST_WAIT: begin
        if (s) begin
          opcode_d = opcode;
          op_d     = op;
          state_d  = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (opcode_q == 3'b110 && op_q == 2'b10)      state_d = ST_WRITE_IMM;
        else if (is_movreg || is_mvn)                 state_d = ST_GETB;
        else if (opcode_q == 3'b101)                  state_d = ST_GETA;
        else                                          state_d = ST_ERROR;
      end
      ST_GETA: state_d = ST_GETB;
      ST_GETB: state_d = ST_ALU;
      ST_ALU: begin
        if (is_cmp) begin
          state_d   = ST_WAIT;
          retired_d = retired_q + 8'd1;
        end else begin
          state_d = ST_WRITE_REG;
        end
      end
      ST_WRITE_REG, ST_WRITE_IMM: begin
        state_d   = ST_WAIT;
        retired_d = retired_q + 8'd1;
      end
      // ERROR is terminal; only reset leaves it.
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_ERROR;
    endcase
  end

  always_comb begin
    w     = 1'b0;
    nsel  = 3'b000;
    loada = 1'b0;
    loadb = 1'b0;
    loadc = 1'b0;
    loads = 1'b0;
    asel  = 1'b0;
    bsel  = 1'b0;
    write = 1'b0;
    vsel  = 2'b00;
    ALUop = 2'b00;
    err   = 1'b0;
    case (state_q)
      ST_WAIT: w = 1'b1;
      ST_GETA: begin
        loada = 1'b1;
        nsel  = 3'b001;
      end
      ST_GETB: begin
        loadb = 1'b1;
        nsel  = 3'b100;
      end
      ST_ALU: begin
        ALUop = is_movreg ? 2'b00 : op_q;
        asel  = is_movreg || is_mvn;
        loadc = !is_cmp;
        loads = is_cmp;
      end
      ST_WRITE_REG: begin
        write = 1'b1;
        nsel  = 3'b010;
      end
      ST_WRITE_IMM: begin
        write = 1'b1;
        nsel  = 3'b001;
        vsel  = 2'b10;
      end
      ST_ERROR: err = 1'b1;
      default: ;
    endcase
  end

  assign retired = retired_q;

endmodule
